// File: rtl/p_decoder_hold.sv
// Registered 3-to-8 decoder: accepts an index over valid/ready, drives its one-hot
// line for HOLD cycles, and keeps a sticky mask of all indices accepted since the last clear.
module p_decoder_hold #(
    parameter int HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inValid,
    input  logic [2:0] inNumber,
    output logic       inReady,
    output logic [7:0] outVector,
    output logic       outValid,
    output logic [7:0] seenMask,
    output logic       allSeen,
    input  logic       clearMask
);
    localparam int WIDTH_OUT = 2**3;

    if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
        $error("p_decoder_hold: HOLD must be in 1..255");
    end

    localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

    typedef enum logic {IDLE, DRIVE} state_t;

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [WIDTH_OUT-1:0]   vec_q, vec_d;
    logic                   vld_q, vld_d;
    logic [WIDTH_OUT-1:0]   mask_q, mask_d;
    logic                   all_q, all_d;
    logic [WIDTH_OUT-1:0]   onehot;
    logic                   accept;

    assign onehot  = WIDTH_OUT'(1) << inNumber;
    assign accept  = inValid && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        vld_d   = vld_q;
        case (state_q)
            IDLE: begin
                if (inValid) begin
                    state_d = DRIVE;
                    cnt_d   = HOLD_M1;
                    vec_d   = onehot;
                    vld_d   = 1'b1;
                end
            end
            DRIVE: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = IDLE;
                    vec_d   = '0;
                    vld_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear takes effect before the newly accepted bit is merged in.
        mask_d = clearMask ? '0 : mask_q;
        if (accept) mask_d = mask_d | onehot;
        all_d = &mask_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            vld_q   <= 1'b0;
            mask_q  <= '0;
            all_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            vld_q   <= vld_d;
            mask_q  <= mask_d;
            all_q   <= all_d;
        end
    end

    assign inReady   = (state_q == IDLE);
    assign outVector = vec_q;
    assign outValid  = vld_q;
    assign seenMask  = mask_q;
    assign allSeen   = all_q;
endmodule

// File: tb/tb_p_decoder_hold.sv
// Directed bench for p_decoder_hold: HOLD=4 instance for most cases, HOLD=1 instance for pulse/spacing.
module tb_p_decoder_hold;
    logic       clk = 1'b0;
    logic       reset;
    logic       inValid, clearMask;
    logic [2:0] inNumber;
    logic       inReady, outValid, allSeen;
    logic [7:0] outVector, seenMask;

    logic       inValid2, clearMask2;
    logic [2:0] inNumber2;
    logic       inReady2, outValid2, allSeen2;
    logic [7:0] outVector2, seenMask2;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_mask;

    always #5 clk = ~clk;

    p_decoder_hold #(.HOLD(4)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inNumber(inNumber),
        .inReady(inReady), .outVector(outVector), .outValid(outValid),
        .seenMask(seenMask), .allSeen(allSeen), .clearMask(clearMask)
    );

    p_decoder_hold #(.HOLD(1)) dut1 (
        .clk(clk), .reset(reset), .inValid(inValid2), .inNumber(inNumber2),
        .inReady(inReady2), .outVector(outVector2), .outValid(outValid2),
        .seenMask(seenMask2), .allSeen(allSeen2), .clearMask(clearMask2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [7:0] vec);
        chk({tag, ".vec"}, outVector, vec);
        chk({tag, ".valid"}, outValid, vec != 8'h00);
        chk({tag, ".ready"}, inReady, vec == 8'h00);
    endtask

    // Accept n at the next edge, then expect exactly 4 cycles of the one-hot value.
    task automatic accept_and_watch(input string tag, input logic [2:0] n);
        logic [7:0] oh;
        oh = 8'h01 << n;
        inValid  = 1'b1;
        inNumber = n;
        step();
        inValid = 1'b0;
        exp_mask = exp_mask | oh;
        chk({tag, ".mask"}, seenMask, exp_mask);
        chk({tag, ".all"}, allSeen, exp_mask == 8'hFF);
        for (int i = 0; i < 4; i++) begin
            chk_out(tag, oh);
            step();
        end
        chk_out({tag, ".end"}, 8'h00);
    endtask

    initial begin
        reset = 1'b1; inValid = 1'b0; inNumber = 3'd0; clearMask = 1'b0;
        inValid2 = 1'b0; inNumber2 = 3'd0; clearMask2 = 1'b0;
        exp_mask = 8'h00;
        step(); step();
        reset = 1'b0;
        step();
        chk_out("rst", 8'h00);
        chk("rst.mask", seenMask, 8'h00);
        chk("rst.all", allSeen, 1'b0);
        step(); step();
        chk_out("idle", 8'h00);

        accept_and_watch("single5", 3'd5);
        chk("single5.mask", seenMask, 8'h20);

        // Busy rejection: index 6 offered during the index-2 pulse must vanish.
        clearMask = 1'b1;
        step();
        clearMask = 1'b0;
        exp_mask = 8'h00;
        chk("clr.mask", seenMask, 8'h00);
        chk_out("clr", 8'h00);
        inValid = 1'b1; inNumber = 3'd2;
        step();
        inNumber = 3'd6;
        chk_out("busy1", 8'h04);
        step();
        chk_out("busy2", 8'h04);
        step();
        inValid = 1'b0;
        chk_out("busy3", 8'h04);
        step();
        chk_out("busy4", 8'h04);
        step();
        chk_out("busy.end", 8'h00);
        chk("busy.mask", seenMask, 8'h04);
        step();
        chk_out("busy.after", 8'h00);

        // Full sweep, accepting as soon as inReady rises (5-cycle spacing).
        clearMask = 1'b1;
        step();
        clearMask = 1'b0;
        exp_mask = 8'h00;
        for (int k = 0; k < 8; k++) accept_and_watch($sformatf("sweep%0d", k), 3'(k));
        chk("sweep.mask", seenMask, 8'hFF);
        chk("sweep.all", allSeen, 1'b1);

        // Clear and accept on the same edge: clear first, then set bit 3.
        clearMask = 1'b1; inValid = 1'b1; inNumber = 3'd3;
        step();
        clearMask = 1'b0; inValid = 1'b0;
        chk("clracc.mask", seenMask, 8'h08);
        chk("clracc.all", allSeen, 1'b0);
        chk_out("clracc", 8'h08);
        step(); step(); step(); step();
        chk_out("clracc.end", 8'h00);

        // Reset on the 2nd cycle of the index-7 pulse truncates it.
        inValid = 1'b1; inNumber = 3'd7;
        step();
        inValid = 1'b0;
        chk_out("mid1", 8'h80);
        step();
        chk_out("mid2", 8'h80);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_out("midrst", 8'h00);
        chk("midrst.mask", seenMask, 8'h00);
        chk("midrst.all", allSeen, 1'b0);
        step();
        chk_out("midrst.after", 8'h00);
        exp_mask = 8'h00;
        accept_and_watch("post1", 3'd1);
        chk("post1.mask", seenMask, 8'h02);

        // HOLD=1: single-cycle pulse, back-to-back accepts 2 cycles apart.
        inValid2 = 1'b1; inNumber2 = 3'd5;
        step();
        inNumber2 = 3'd6;
        chk("h1.vec5", outVector2, 8'h20);
        chk("h1.rdy5", inReady2, 1'b0);
        step();
        chk("h1.gap", outVector2, 8'h00);
        chk("h1.rdygap", inReady2, 1'b1);
        step();
        inValid2 = 1'b0;
        chk("h1.vec6", outVector2, 8'h40);
        chk("h1.val6", outValid2, 1'b1);
        step();
        chk("h1.end", outVector2, 8'h00);
        chk("h1.mask", seenMask2, 8'h60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/p_decoder_hold.md
Name: p_decoder_hold

Overview:
Registered 3-to-8 decoder, the counterpart of the team's 8-to-3 priority encoder. It accepts an encoded index over a valid/ready handshake and drives the matching one-hot line for a fixed number of cycles. It also keeps a sticky mask of every index accepted since the last clear. It sits downstream of the encoder and turns encoded grants back into per-line strobes.

Parameters:
HOLD, 4, cycles each one-hot output stays asserted; legal range 1..255, 0 is illegal (elaboration error).
WIDTH_OUT, 8, fixed local value 2**3, not overridable.

Ports:
clk  input  1  clock, all state updates on the rising edge
reset  input  1  synchronous, active-high reset
inValid  input  1  inNumber carries a request
inNumber  input  3  index to decode, 0..7
inReady  output  1  block can accept; high only in IDLE
outVector  output  8  one-hot decoded value, or 8'h00
outValid  output  1  high exactly while outVector is non-zero
seenMask  output  8  sticky OR of all accepted one-hot values
allSeen  output  1  high when seenMask == 8'hFF
clearMask  input  1  synchronous clear of seenMask

Behaviour:
- Reset: reset is synchronous and active-high, sampled on the clk rising edge. On reset, state goes to IDLE and the counter, outVector, outValid, seenMask and allSeen all become 0. The cycle after reset deasserts, inReady is 1. While reset is high, inValid and clearMask are ignored.
- States: IDLE and DRIVE.
- inReady is a combinational decode of state: (state == IDLE). It has no combinational path from inValid.
- Accept: a handshake completes on an edge where inValid && inReady. On that edge:
  - state goes to DRIVE
  - outVector <= 8'b1 << inNumber
  - outValid <= 1
  - counter <= HOLD-1
  - seenMask <= seenMask | (8'b1 << inNumber)
  - The output therefore appears 1 cycle after acceptance (latency 1).
- DRIVE: outVector and outValid hold. On each edge with counter != 0, the counter decrements. On the edge where counter == 0:
  - state goes to IDLE
  - outVector <= 0
  - outValid <= 0
- Timing: outVector is non-zero for exactly HOLD consecutive cycles. inReady rises on the same cycle outVector returns to 0. The minimum accept-to-accept spacing is HOLD+1 cycles. With HOLD=1 the pulse lasts 1 cycle and the spacing is 2 cycles.
- inValid while in DRIVE: ignored and not queued. The upstream must hold inValid until it sees inReady.
- Counter width: 8 bits. The counter never wraps below 0.
- clearMask: on an edge with clearMask=1, seenMask <= 0.
  - If an accept happens on the same edge, the result is seenMask <= (8'b1 << inNumber). Clear is applied first, then the new bit is set.
  - clearMask never affects outVector or state.
- allSeen is registered and updated from the next value of seenMask, so it is high in the same cycle seenMask reads 8'hFF.
- Reset in DRIVE: the pulse is truncated. On the reset edge outVector goes to 0 and state to IDLE. No partial hold continues afterwards.
- Duplicate indices: accepting an index already in seenMask still produces a full pulse; seenMask is unchanged.
- Invariants:
  - outVector always has $countones <= 1.
  - outValid == |outVector.
  - inReady == !outValid.

Test Plan:
- Reset then idle: hold reset 2 cycles, then release -> all outputs 0 and inReady=1 on the first cycle after release; no change while inValid=0.
- Single decode, HOLD=4: accept inNumber=5 at edge t -> outVector=8'h20 and outValid=1 for edges t+1..t+4; outVector=8'h00 and inReady=1 from t+5; seenMask=8'h20.
- Busy rejection: during the DRIVE of index 2, drive inValid=1 with inNumber=6 for 2 cycles, then drop it -> index 6 never appears; outVector stays 8'h04 for 4 cycles; seenMask=8'h04.
- Full sweep: accept indices 0..7 back-to-back, each accepted as soon as inReady rises -> each pulse has the correct one-hot value; seenMask grows to 8'hFF and allSeen rises in the cycle after index 7 is accepted; accepts are 5 cycles apart.
- Simultaneous clear and accept: seenMask=8'hFF, then clearMask=1 on the same edge as accepting index 3 -> seenMask=8'h08 and allSeen=0.
- Reset mid-pulse, HOLD=4: assert reset on the 2nd cycle of the index-7 pulse -> outVector=0 on the next cycle; seenMask=0; then accept index 1 -> a full 4-cycle pulse of 8'h02. Repeat the single-decode case with HOLD=1 -> a 1-cycle pulse and 2-cycle spacing.
